// File: rtl/gpr_mp_sb_if.sv
// Register file bus: decode read ports, issue, writeback and busy count.
// Master is the pipeline side, slave is the register file.
interface gpr_mp_sb_if #(
    parameter int XLEN     = 64,
    parameter int NREG     = 32,
    parameter int RD_PORTS = 2,
    parameter int WR_PORTS = 2
);
    localparam int AW = $clog2(NREG);

    logic [RD_PORTS*AW-1:0]   rd_addr;
    logic [RD_PORTS*XLEN-1:0] rd_data;
    logic [RD_PORTS-1:0]      rd_busy;
    logic                     iss_valid;
    logic [AW-1:0]            iss_rd;
    logic                     iss_wen;
    logic [WR_PORTS-1:0]      wb_valid;
    logic [WR_PORTS-1:0]      wb_trap;
    logic [WR_PORTS-1:0]      wb_wen;
    logic [WR_PORTS*AW-1:0]   wb_rd;
    logic [WR_PORTS*XLEN-1:0] wb_data;
    logic                     flush;
    logic [AW:0]              busy_cnt;

    modport master (
        output rd_addr, iss_valid, iss_rd, iss_wen,
        output wb_valid, wb_trap, wb_wen, wb_rd, wb_data, flush,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_addr, iss_valid, iss_rd, iss_wen,
        input  wb_valid, wb_trap, wb_wen, wb_rd, wb_data, flush,
        output rd_data, rd_busy, busy_cnt
    );
endinterface

// File: rtl/gpr_mp_sb.sv
// Multi-port integer register file with pending-write scoreboard.
// Optional same-cycle write-to-read forwarding under GPR_BYPASS_EN.
module gpr_mp_sb #(
    parameter int XLEN     = 64,
    parameter int NREG     = 32,
    parameter int RD_PORTS = 2,
    parameter int WR_PORTS = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    gpr_mp_sb_if.slave     bus
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0]          regs_q [NREG];
    logic [XLEN-1:0]          regs_d [NREG];
    logic [NREG-1:0]          busy_q, busy_d;
    logic [AW:0]              busy_cnt_q, busy_cnt_d;
    logic [WR_PORTS-1:0]      wr_ok;
    logic [NREG-1:0]          set_v, clr_v;
    logic [RD_PORTS*XLEN-1:0] rd_data_c;
    logic [RD_PORTS-1:0]      rd_busy_c;

    always_comb begin
        wr_ok = '0;
        for (int j = 0; j < WR_PORTS; j++) begin
            wr_ok[j] = bus.wb_valid[j] & ~bus.wb_trap[j] & bus.wb_wen[j]
                     & (bus.wb_rd[j*AW +: AW] != '0)
                     & (int'(bus.wb_rd[j*AW +: AW]) < NREG);
        end
    end

    // Ascending port order lets the youngest write land last.
    always_comb begin
        for (int r = 0; r < NREG; r++) regs_d[r] = regs_q[r];
        for (int j = 0; j < WR_PORTS; j++) begin
            if (wr_ok[j]) regs_d[bus.wb_rd[j*AW +: AW]] = bus.wb_data[j*XLEN +: XLEN];
        end
    end

    always_comb begin
        set_v = '0;
        clr_v = '0;
        for (int r = 1; r < NREG; r++) begin
            set_v[r] = bus.iss_valid & bus.iss_wen & (bus.iss_rd == AW'(r));
            for (int j = 0; j < WR_PORTS; j++) begin
                if (bus.wb_valid[j] & bus.wb_wen[j] & (bus.wb_rd[j*AW +: AW] == AW'(r)))
                    clr_v[r] = 1'b1;
            end
        end
    end

    always_comb begin
        busy_d     = '0;
        busy_cnt_d = '0;
        for (int r = 1; r < NREG; r++) begin
            busy_d[r] = bus.flush ? set_v[r] : (set_v[r] | (busy_q[r] & ~clr_v[r]));
            busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[r]};
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int i = 0; i < RD_PORTS; i++) begin
            if (bus.rd_addr[i*AW +: AW] != '0 && int'(bus.rd_addr[i*AW +: AW]) < NREG) begin
                rd_data_c[i*XLEN +: XLEN] = regs_q[bus.rd_addr[i*AW +: AW]];
                rd_busy_c[i]              = busy_q[bus.rd_addr[i*AW +: AW]];
`ifdef GPR_BYPASS_EN
                for (int j = 0; j < WR_PORTS; j++) begin
                    if (wr_ok[j] && bus.wb_rd[j*AW +: AW] == bus.rd_addr[i*AW +: AW])
                        rd_data_c[i*XLEN +: XLEN] = bus.wb_data[j*XLEN +: XLEN];
                end
                if (clr_v[bus.rd_addr[i*AW +: AW]] && !set_v[bus.rd_addr[i*AW +: AW]])
                    rd_busy_c[i] = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) regs_q[r] <= regs_d[r];
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_gpr_mp_sb.sv
// Directed self-checking bench for gpr_mp_sb.
// Inputs change 1ns after the rising edge; outputs are sampled mid-cycle.
module tb_gpr_mp_sb;
    localparam int XLEN = 64;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    gpr_mp_sb_if #(.XLEN(64), .NREG(32), .RD_PORTS(2), .WR_PORTS(2)) bus ();

    gpr_mp_sb #(.XLEN(64), .NREG(32), .RD_PORTS(2), .WR_PORTS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.iss_valid = 1'b0;
        bus.iss_wen   = 1'b0;
        bus.iss_rd    = '0;
        bus.wb_valid  = '0;
        bus.wb_trap   = '0;
        bus.wb_wen    = '0;
        bus.wb_rd     = '0;
        bus.wb_data   = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        bus.rd_addr[p*AW +: AW] = a;
    endtask

    task automatic wb(input int p, input logic [AW-1:0] r, input logic [63:0] d,
                      input logic trap);
        bus.wb_valid[p]           = 1'b1;
        bus.wb_wen[p]             = 1'b1;
        bus.wb_trap[p]            = trap;
        bus.wb_rd[p*AW +: AW]     = r;
        bus.wb_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic iss(input logic [AW-1:0] r);
        bus.iss_valid = 1'b1;
        bus.iss_wen   = 1'b1;
        bus.iss_rd    = r;
    endtask

    function automatic logic [63:0] dat(input int p);
        return bus.rd_data[p*XLEN +: XLEN];
    endfunction

    initial begin
        rst_n = 1'b0;
        bus.rd_addr = '0;
        idle();
        #3;
        chk("reset_cnt", 64'(bus.busy_cnt), 64'd0);
        #9 rst_n = 1'b1;
        tick();

        for (int a = 0; a < 32; a++) begin
            rd(0, AW'(a));
            rd(1, AW'(31 - a));
            #1;
            chk("reset_data", bus.rd_data[63:0] | bus.rd_data[127:64], 64'd0);
            chk("reset_busy", 64'(bus.rd_busy), 64'd0);
        end
        chk("reset_cnt2", 64'(bus.busy_cnt), 64'd0);

        wb(0, 5'd5, 64'hDEAD_BEEF_0000_0001, 1'b0);
        tick();
        idle();
        rd(0, 5'd5);
        #1 chk("wr_x5", dat(0), 64'hDEAD_BEEF_0000_0001);

        wb(1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        tick();
        idle();
        rd(0, 5'd0);
        #1 chk("wr_x0", dat(0), 64'd0);

        wb(0, 5'd7, 64'h11, 1'b0);
        wb(1, 5'd7, 64'h22, 1'b0);
        tick();
        idle();
        rd(0, 5'd5);
        rd(1, 5'd7);
        #1 chk("dual_wr_x7", dat(1), 64'h22);
        chk("port0_x5", dat(0), 64'hDEAD_BEEF_0000_0001);

        wb(0, 5'd7, 64'h11, 1'b0);
        wb(1, 5'd7, 64'h22, 1'b1);
        tick();
        idle();
        #1 chk("trap_wr_x7", dat(1), 64'h11);

        iss(5'd3);
        tick();
        idle();
        rd(0, 5'd3);
        #1 chk("iss_cnt", 64'(bus.busy_cnt), 64'd1);
        chk("iss_busy", 64'(bus.rd_busy[0]), 64'd1);

        iss(5'd3);
        wb(0, 5'd3, 64'h33, 1'b0);
        tick();
        idle();
        #1 chk("reiss_busy", 64'(bus.rd_busy[0]), 64'd1);
        chk("reiss_cnt", 64'(bus.busy_cnt), 64'd1);
        chk("reiss_data", dat(0), 64'h33);

        wb(1, 5'd3, 64'h34, 1'b0);
        tick();
        idle();
        #1 chk("clr_busy", 64'(bus.rd_busy[0]), 64'd0);
        chk("clr_cnt", 64'(bus.busy_cnt), 64'd0);
        chk("clr_data", dat(0), 64'h34);

        iss(5'd1);
        tick();
        iss(5'd2);
        tick();
        iss(5'd4);
        tick();
        idle();
        #1 chk("three_cnt", 64'(bus.busy_cnt), 64'd3);

        bus.flush = 1'b1;
        iss(5'd9);
        wb(0, 5'd2, 64'h55, 1'b0);
        tick();
        idle();
        rd(0, 5'd9);
        rd(1, 5'd2);
        #1 chk("flush_cnt", 64'(bus.busy_cnt), 64'd1);
        chk("flush_busy9", 64'(bus.rd_busy[0]), 64'd1);
        chk("flush_busy2", 64'(bus.rd_busy[1]), 64'd0);
        chk("flush_wr_x2", dat(1), 64'h55);

        iss(5'd0);
        tick();
        idle();
        #1 chk("iss_x0_cnt", 64'(bus.busy_cnt), 64'd1);

        wb(0, 5'd9, 64'h99, 1'b1);
        tick();
        idle();
        #1 chk("trap_clr_cnt", 64'(bus.busy_cnt), 64'd0);
        chk("trap_no_wr", dat(0), 64'd0);

        wb(0, 5'd6, 64'h1111, 1'b0);
        tick();
        iss(5'd6);
        tick();
        idle();
        rd(0, 5'd6);
        wb(0, 5'd6, 64'hABCD, 1'b0);
        #1;
`ifdef GPR_BYPASS_EN
        chk("byp_data", dat(0), 64'hABCD);
        chk("byp_busy", 64'(bus.rd_busy[0]), 64'd0);
`else
        chk("nobyp_data", dat(0), 64'h1111);
        chk("nobyp_busy", 64'(bus.rd_busy[0]), 64'd1);
`endif
        tick();
        idle();
        #1 chk("after_data", dat(0), 64'hABCD);
        chk("after_busy", 64'(bus.rd_busy[0]), 64'd0);

        wb(0, 5'd10, 64'hA0A0, 1'b0);
        iss(5'd11);
        tick();
        wb(1, 5'd12, 64'hB0B0, 1'b0);
        iss(5'd13);
        rd(0, 5'd10);
        rd(1, 5'd5);
        #1 chk("burst_cnt", 64'(bus.busy_cnt), 64'd1);
        chk("burst_x10", dat(0), 64'hA0A0);
        #1 rst_n = 1'b0;
        #1 chk("async_cnt", 64'(bus.busy_cnt), 64'd0);
        chk("async_x10", dat(0), 64'd0);
        chk("async_x5", dat(1), 64'd0);
        idle();
        #3 rst_n = 1'b1;
        tick();
        rd(0, 5'd12);
        #1 chk("async_x12", dat(0), 64'd0);
        chk("async_cnt2", 64'(bus.busy_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
